// File: rtl/mac_seq_ctrl_pkg.sv
// Shared definitions for the MAC lane sequencer: default datapath widths and
// the controller state encoding used by the lanes and the layer scheduler.
package mac_seq_ctrl_pkg;

    localparam int I_BW      = 8;
    localparam int W_BW      = 8;
    localparam int O_CONV_BW = 20;
    localparam int ADDR_BW   = 8;
    localparam int CNT_BW    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

endpackage

// File: rtl/mac_seq_ctrl_tap_addr_gen.sv
// Tap counter with paired input/weight address incrementers; addresses wrap
// naturally at 2^ADDR_BW. o_last_tap flags the final tap of the dot product.
module tap_addr_gen #(
    parameter int ADDR_BW = mac_seq_ctrl_pkg::ADDR_BW,
    parameter int CNT_BW  = mac_seq_ctrl_pkg::CNT_BW
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic               i_step,
    input  logic [ADDR_BW-1:0] i_base_i,
    input  logic [ADDR_BW-1:0] i_base_w,
    input  logic [CNT_BW-1:0]  i_num_taps,
    output logic [ADDR_BW-1:0] o_i_addr,
    output logic [ADDR_BW-1:0] o_w_addr,
    output logic               o_last_tap
);
    import mac_seq_ctrl_pkg::*;

    logic [CNT_BW-1:0]  r_idx;
    logic [CNT_BW-1:0]  r_last_idx;
    logic [ADDR_BW-1:0] r_i_addr;
    logic [ADDR_BW-1:0] r_w_addr;

    // Tap index and address registers: load bases on start, advance once per issued tap
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_idx      <= {CNT_BW{1'b0}};
            r_last_idx <= {CNT_BW{1'b0}};
            r_i_addr   <= {ADDR_BW{1'b0}};
            r_w_addr   <= {ADDR_BW{1'b0}};
        end else if (i_load) begin
            r_idx      <= {CNT_BW{1'b0}};
            r_last_idx <= i_num_taps - {{(CNT_BW-1){1'b0}}, 1'b1};
            r_i_addr   <= i_base_i;
            r_w_addr   <= i_base_w;
        end else if (i_step) begin
            r_idx      <= r_idx + {{(CNT_BW-1){1'b0}}, 1'b1};
            r_i_addr   <= r_i_addr + {{(ADDR_BW-1){1'b0}}, 1'b1};
            r_w_addr   <= r_w_addr + {{(ADDR_BW-1){1'b0}}, 1'b1};
        end else begin
            r_idx      <= r_idx;
            r_i_addr   <= r_i_addr;
            r_w_addr   <= r_w_addr;
        end
    end

    assign o_i_addr   = r_i_addr;
    assign o_w_addr   = r_w_addr;
    assign o_last_tap = (r_idx == r_last_idx);

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer for one MAC lane: issues buffer reads, steers the MAC
// bias/feedback input and hands the sum out on valid/ready.
// Build option: MAC_SEQ_CTRL_RELU_EN clamps negative results to zero at capture.
module mac_seq_ctrl #(
    parameter int O_CONV_BW = mac_seq_ctrl_pkg::O_CONV_BW,
    parameter int ADDR_BW   = mac_seq_ctrl_pkg::ADDR_BW,
    parameter int CNT_BW    = mac_seq_ctrl_pkg::CNT_BW
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    input  logic [CNT_BW-1:0]           i_num_taps,
    input  logic [ADDR_BW-1:0]          i_base_i_addr,
    input  logic [ADDR_BW-1:0]          i_base_w_addr,
    input  logic signed [O_CONV_BW-1:0] i_bias,
    output logic                        o_busy,
    output logic                        o_rd_en,
    output logic [ADDR_BW-1:0]          o_i_addr,
    output logic [ADDR_BW-1:0]          o_w_addr,
    output logic                        o_mac_ce,
    output logic                        o_mac_rst,
    output logic signed [O_CONV_BW-1:0] o_mac_c,
    input  logic signed [O_CONV_BW-1:0] i_mac_p,
    output logic                        o_out_valid,
    input  logic                        i_out_ready,
    output logic signed [O_CONV_BW-1:0] o_out_data
);
    import mac_seq_ctrl_pkg::*;

    state_e                      r_state;
    state_e                      w_state_nxt;
    logic                        w_accept;
    logic                        w_issue;
    logic                        w_capture;
    logic                        w_last_tap;
    logic                        r_mac_ce;
    logic                        r_first;
    logic signed [O_CONV_BW-1:0] r_bias;
    logic signed [O_CONV_BW-1:0] r_out_data;
    logic signed [O_CONV_BW-1:0] w_cap_val;
    logic signed [O_CONV_BW-1:0] w_mac_c;
    logic [ADDR_BW-1:0]          w_i_addr;
    logic [ADDR_BW-1:0]          w_w_addr;

    assign w_accept = (r_state == ST_IDLE) && i_start && (i_num_taps != {CNT_BW{1'b0}});
    assign w_issue  = (r_state == ST_ISSUE);

    tap_addr_gen #(
        .ADDR_BW (ADDR_BW),
        .CNT_BW  (CNT_BW)
    ) u_tap_addr_gen (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_accept),
        .i_step     (w_issue),
        .i_base_i   (i_base_i_addr),
        .i_base_w   (i_base_w_addr),
        .i_num_taps (i_num_taps),
        .o_i_addr   (w_i_addr),
        .o_w_addr   (w_w_addr),
        .o_last_tap (w_last_tap)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; DRAIN waits for the delayed ce to fall so p holds the final tap
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (w_last_tap) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (!r_mac_ce) begin
                    w_state_nxt = ST_OUT;
                    w_capture   = 1'b1;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_OUT: begin
                if (i_out_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_OUT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath registers: ce delay, first-tap flag, latched bias and captured result
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mac_ce   <= 1'b0;
            r_first    <= 1'b0;
            r_bias     <= {O_CONV_BW{1'b0}};
            r_out_data <= {O_CONV_BW{1'b0}};
        end else begin
            r_mac_ce <= w_issue;
            if (w_accept) begin
                r_bias  <= i_bias;
                r_first <= 1'b1;
            end else if (r_mac_ce) begin
                r_first <= 1'b0;
            end
            if (w_capture) begin
                r_out_data <= w_cap_val;
            end
        end
    end

    // Result shaping applied at capture time
    always_comb begin
        w_cap_val = i_mac_p;
`ifdef MAC_SEQ_CTRL_RELU_EN
        if (i_mac_p[O_CONV_BW-1]) begin
            w_cap_val = {O_CONV_BW{1'b0}};
        end else begin
            w_cap_val = i_mac_p;
        end
`endif
    end

    // MAC addend: bias seeds the first accumulation, p feeds back afterwards
    always_comb begin
        w_mac_c = {O_CONV_BW{1'b0}};
        if (r_mac_ce && r_first) begin
            w_mac_c = r_bias;
        end else if (r_mac_ce) begin
            w_mac_c = i_mac_p;
        end else begin
            w_mac_c = {O_CONV_BW{1'b0}};
        end
    end

    assign o_busy      = !i_rst && (r_state != ST_IDLE);
    assign o_rd_en     = !i_rst && w_issue;
    assign o_i_addr    = i_rst ? {ADDR_BW{1'b0}} : w_i_addr;
    assign o_w_addr    = i_rst ? {ADDR_BW{1'b0}} : w_w_addr;
    assign o_mac_ce    = !i_rst && r_mac_ce;
    assign o_mac_rst   = i_rst || w_accept;
    assign o_mac_c     = i_rst ? {O_CONV_BW{1'b0}} : w_mac_c;
    assign o_out_valid = !i_rst && (r_state == ST_OUT);
    assign o_out_data  = i_rst ? {O_CONV_BW{1'b0}} : r_out_data;

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencer for one `mac` datapath instance: on `start` it walks a dot product of `num_taps` input/weight pairs through the MAC. It issues read addresses to the input and weight buffers (1-cycle synchronous read), drives the MAC's `ce`, `rst` and `c` (bias on the first tap, feedback of `p` afterwards), and captures the finished sum. It sits between the convolution layer scheduler and each MAC lane and presents the result on a valid/ready output.

## Interface
- `I_BW`, 8: input activation width (matches MAC `a`)
- `W_BW`, 8: weight width (matches MAC `b`)
- `O_CONV_BW`, 20: accumulator/result width (matches MAC `c`/`p`)
- `ADDR_BW`, 8: buffer address width
- `CNT_BW`, 8: tap-count width
- `clk` in 1: single clock; all logic on rising edge
- `rst` in 1: reset, synchronous, active-high
- `start` in 1: request a new dot product; sampled only in IDLE
- `num_taps` in CNT_BW: tap count, latched at start
- `base_i_addr` in ADDR_BW: first input-buffer address, latched at start
- `base_w_addr` in ADDR_BW: first weight-buffer address, latched at start
- `bias` in O_CONV_BW (signed): initial accumulator value, latched at start
- `busy` out 1: high whenever state ≠ IDLE
- `rd_en` out 1: buffer read strobe
- `i_addr` out ADDR_BW: input-buffer read address
- `w_addr` out ADDR_BW: weight-buffer read address
- `mac_ce` out 1: drives MAC `ce`
- `mac_rst` out 1: drives MAC `rst`
- `mac_c` out O_CONV_BW (signed): drives MAC `c`
- `mac_p` in O_CONV_BW (signed): MAC `p`
- `out_valid` out 1: result available
- `out_ready` in 1: consumer accepts result
- `out_data` out O_CONV_BW (signed): result

## Operation
- States: IDLE → ISSUE → DRAIN → OUT → IDLE.
- IDLE: `start`=1 with `num_taps`≥1 latches the inputs, pulses `mac_rst` for that cycle and moves to ISSUE. `start` with `num_taps`=0 is ignored (stay IDLE, no output). `start` outside IDLE is ignored.
- ISSUE: one tap per cycle, `rd_en`=1, `i_addr`=base_i+k, `w_addr`=base_w+k, for k=0..N−1. Addresses wrap modulo 2^ADDR_BW. After k=N−1 go to DRAIN.
- `mac_ce` is `rd_en` delayed by one register, aligned with buffer data. A registered first-tap flag makes `mac_c`=latched bias on the first `mac_ce` cycle; otherwise `mac_c`=`mac_p`.
- DRAIN: wait until the last `mac_ce` has updated `p`. Register `out_data` from `mac_p`, go to OUT.
- OUT: `out_valid`=1 and `out_data` held stable until `out_valid`&&`out_ready`, then IDLE.
- Arithmetic: the MAC wraps at O_CONV_BW; the controller neither saturates nor checks overflow.
- Reset (any state, including mid-ISSUE): next cycle is IDLE. All outputs 0 except `mac_rst`=1 while `rst` is high. Latched registers clear to 0.

## Timing
- `start` sampled in cycle 0. `rd_en` is high in cycles 1..N. `mac_ce` is high in cycles 2..N+1.
- `p` is final after the edge ending cycle N+1. `out_valid` rises in cycle N+3.
- Start-to-`out_valid` latency is N+3 cycles. Minimum start-to-start interval is N+4 cycles (back-to-back `out_ready`=1).
- `busy` falls in the cycle after the accepting handshake. A `start` in that cycle is accepted.

## Configuration
- `MAC_SEQ_CTRL_RELU_EN` defined: `out_data` = 0 when the captured `mac_p` is negative, else `mac_p`. Applied at capture, with no added latency.
- Undefined: `out_data` = `mac_p` unmodified, signed.

## Structure
- A shared package holds the state enum (IDLE, ISSUE, DRAIN, OUT) and the default width constants (I_BW, W_BW, O_CONV_BW, ADDR_BW, CNT_BW), so MAC lanes and the layer scheduler share them.
- Sub-module `tap_addr_gen`: tap counter plus dual address incrementer with wrap. It exposes `last_tap`.
- FSM and `mac_c` mux stay in the top level.
- The MAC itself is instantiated by the parent, not inside this block.

## Test plan
- N=3, inputs 1,2,3, weights 4,5,6, bias 10, `out_ready`=1 → `out_data`=42, `out_valid` in cycle 6, `rd_en` in cycles 1–3.
- N=1, input −5, weight 7, bias 0 → `out_data`=−35 without macro; 0 with `MAC_SEQ_CTRL_RELU_EN`.
- `base_i_addr`=254, `base_w_addr`=0, N=4 → `i_addr` 254,255,0,1; `w_addr` 0,1,2,3.
- `out_ready` low 5 cycles after `out_valid` → `out_data` stable, `busy`=1. A `start` pulse during that window is ignored, with no second result.
- `rst` asserted in cycle 2 of an N=8 run → IDLE next cycle, `rd_en`/`mac_ce`/`out_valid`=0, `mac_rst`=1 during reset. A fresh N=2 run then yields the correct sum.
- `start` with `num_taps`=0 → stays IDLE, `busy`=0, no `rd_en`, no `out_valid`.
